// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder.
//   DEF_WIDTH  : default operand/result width
//   DEF_STAGES : default number of pipeline stages (one slice per stage)
// Optional build macro ADDER_SUB_EN adds a subtract mode to pipelined_adder.
package adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    // Bit offset of slice k inside a WIDTH-bit word.
    function automatic int slice_lo(input int k, input int slice_w);
        return k * slice_w;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry slice.
//   a_i, b_i : slice operands
//   c_i      : carry into bit 0 of the slice
//   s_o      : slice sum
//   c_o      : carry out of the slice MSB
//   c_msb_o  : carry into the slice MSB (used for signed overflow on the top slice)
module adder_slice
    import adder_pkg::*;
#(
    parameter int W = DEF_WIDTH / DEF_STAGES
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o,
    output logic         c_msb_o
);

    always_comb begin : ripple
        logic c;
        c       = c_i;
        s_o     = '0;
        c_msb_o = 1'b0;
        for (int i = 0; i < W; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c;
            if (i == W - 1) c_msb_o = c;
            c = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        c_o = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit A + B + carry_i over STAGES
// register stages, one SLICE_W = WIDTH/STAGES slice per stage, with a
// valid/ready handshake and a single global advance enable.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   valid_i / ready_o : input handshake (ready_o = advance enable)
//   a_i, b_i, carry_i : operands and carry-in
//   sub_i             : subtract mode (only when ADDER_SUB_EN is defined)
//   valid_o / ready_i : output handshake
//   sum_o, carry_o    : result and carry out of the MSB
//   ovf_o             : two's-complement signed overflow
// Build macro ADDER_SUB_EN: adds sub_i; A - B - carry_i (carry_i is borrow-in,
// carry_o is NOT-borrow). Without it, add only and no inversion logic exists.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
`ifdef ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam int SLICE_W = WIDTH / STAGES;

    generate
        if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
            $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
        end
    endgenerate

    // Per-stage register: sum holds the finished lower slices, a/b carry the
    // operands forward so later stages can pick up their upper slices.
    typedef struct packed {
        logic             valid;
        logic             carry;  // carry out of this stage's slice
        logic             c_msb;  // carry into this stage's slice MSB
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t [STAGES-1:0] st_q, st_d;
    stage_t              in_st;
    stage_t [STAGES:0]   chain;   // chain[k] feeds stage k

    logic [STAGES-1:0][SLICE_W-1:0] sl_sum;
    logic [STAGES-1:0]              sl_co, sl_cm;
    logic                           adv;

    assign adv     = ready_i | ~valid_o;
    assign ready_o = adv;

    // Subtraction is folded in once at the input: B is inverted for all
    // slices and the carry-in is inverted, so the stages only ever add.
    always_comb begin
        in_st       = '0;
        in_st.valid = valid_i;
        in_st.a     = a_i;
`ifdef ADDER_SUB_EN
        in_st.sub   = sub_i;
        in_st.b     = sub_i ? ~b_i : b_i;
        in_st.carry = carry_i ^ sub_i;
`else
        in_st.b     = b_i;
        in_st.carry = carry_i;
`endif
    end

    assign chain[0]        = in_st;
    assign chain[STAGES:1] = st_q;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            adder_slice #(.W(SLICE_W)) u_slice (
                .a_i     (chain[k].a[slice_lo(k, SLICE_W) +: SLICE_W]),
                .b_i     (chain[k].b[slice_lo(k, SLICE_W) +: SLICE_W]),
                .c_i     (chain[k].carry),
                .s_o     (sl_sum[k]),
                .c_o     (sl_co[k]),
                .c_msb_o (sl_cm[k])
            );
        end
    endgenerate

    always_comb begin
        st_d = st_q;
        for (int k = 0; k < STAGES; k++) begin
            st_d[k]                             = chain[k];
            st_d[k].sum[k*SLICE_W +: SLICE_W]   = sl_sum[k];
            st_d[k].carry                       = sl_co[k];
            st_d[k].c_msb                       = sl_cm[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q <= '0;
        end else if (adv) begin
            st_q <= st_d;
        end
    end

    assign valid_o = st_q[STAGES-1].valid;
    assign sum_o   = st_q[STAGES-1].sum;
    assign carry_o = st_q[STAGES-1].carry;
    assign ovf_o   = st_q[STAGES-1].carry ^ st_q[STAGES-1].c_msb;

    // Operands and mode are fully consumed by the last stage.
    logic unused_tail;
    assign unused_tail = ^{st_q[STAGES-1].a, st_q[STAGES-1].b, st_q[STAGES-1].sub};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=8, STAGES=2).
// Build with ADDER_SUB_EN defined to include the subtract vectors.
module tb_pipelined_adder;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_i, valid_i, ready_i, carry_i, sub_i;
    logic         ready_o, valid_o, carry_o, ovf_o;
    logic [W-1:0] a_i, b_i, sum_o;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .carry_i (carry_i),
`ifdef ADDER_SUB_EN
        .sub_i   (sub_i),
`endif
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sum_o   (sum_o),
        .carry_o (carry_o),
        .ovf_o   (ovf_o)
    );

    typedef logic [W+1:0] res_t;  // {carry, ovf, sum}
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
        res_t         exp;
    } vec_t;

    vec_t tbl[$];
    res_t sbq[$];
    int   n_cmp = 0, n_bad = 0, n_push = 0, n_pop = 0, n_disc = 0;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   r;
        logic         ov;
        bb = s ? ~b : b;
        ci = s ? ~c : c;
        r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        ov = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return {r[W], ov, r[W-1:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon();
        res_t e;
        if (!rst_i && valid_o && ready_i) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %h want none (t=%0t)",
                         {carry_o, ovf_o, sum_o}, $time);
            end else begin
                e = sbq.pop_front();
                n_pop++;
                chk("result", 32'({carry_o, ovf_o, sum_o}), 32'(e));
            end
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
        a_i = a; b_i = b; carry_i = c; sub_i = s; valid_i = 1'b1;
    endtask

    // One clock: decide acceptance, check output at negedge, land #1 after posedge.
    task automatic tick(input res_t e, output bit acc);
        #1;
        acc = valid_i && ready_o;
        if (acc) begin
            sbq.push_back(e);
            n_push++;
        end
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < n; i++) tick('0, acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           acc;
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        res_t         e, e1, e2, e3;

        tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h00}});
        tbl.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h80}});
        tbl.push_back('{8'h80, 8'h80, 1'b0, 1'b0, {1'b1, 1'b1, 8'h00}});
        tbl.push_back('{8'h00, 8'h00, 1'b1, 1'b0, {1'b0, 1'b0, 8'h01}});
        tbl.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, {1'b1, 1'b0, 8'hFF}});
        tbl.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h10}});
        tbl.push_back('{8'h7F, 8'h7F, 1'b1, 1'b0, {1'b0, 1'b1, 8'hFF}});
        tbl.push_back('{8'h55, 8'hAA, 1'b1, 1'b0, {1'b1, 1'b0, 8'h00}});
`ifdef ADDER_SUB_EN
        tbl.push_back('{8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE}});
        tbl.push_back('{8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F}});
        tbl.push_back('{8'h10, 8'h10, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFF}});
`endif

        // Reset state
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; carry_i = 1'b0; sub_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_sum",   32'(sum_o),   0);
        chk("rst_carry", 32'(carry_o), 0);
        chk("rst_ovf",   32'(ovf_o),   0);
        rst_i = 1'b0;
        #1;
        chk("rst_ready", 32'(ready_o), 1);

        // Table vectors back to back, with first-result latency check
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s);
            tick(tbl[i].exp, acc);
            chk("tbl_accept", 32'(acc), 1);
            if (i == 0) chk("lat_c1_valid", 32'(valid_o), 0);
            if (i == 1) chk("lat_c2_valid", 32'(valid_o), 1);
        end
        idle(S + 2);

        // 100 random back-to-back ops at full throughput
        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            e = model(ra, rb, rc, rs);
            drive(ra, rb, rc, rs);
            tick(e, acc);
            chk("b2b_accept", 32'(acc), 1);
        end
        idle(S + 2);

        // Random downstream backpressure
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            e = model(ra, rb, rc, rs);
            drive(ra, rb, rc, rs);
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                ready_i = 1'($urandom);
                tick(e, acc);
            end
            chk("bp_send_in_time", 32'(acc), 1);
        end
        idle(S + 4);

        // Full pipeline, ready_i low for 3 cycles: outputs frozen
        e1 = model(8'h3C, 8'h4D, 1'b0, 1'b0);
        e2 = model(8'hC8, 8'h64, 1'b1, 1'b0);
        e3 = model(8'h01, 8'hFE, 1'b1, 1'b0);
        ready_i = 1'b1;
        drive(8'h3C, 8'h4D, 1'b0, 1'b0); tick(e1, acc);
        drive(8'hC8, 8'h64, 1'b1, 1'b0); tick(e2, acc);
        ready_i = 1'b0;
        drive(8'h01, 8'hFE, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", 32'(ready_o), 0);
            chk("stall_valid", 32'(valid_o), 1);
            chk("stall_hold",  32'({carry_o, ovf_o, sum_o}), 32'(e1));
            tick(e3, acc);
        end
        ready_i = 1'b1;
        tick(e3, acc);
        chk("release_accept", 32'(acc), 1);
        idle(S + 2);

        // Reset with two ops in flight: both discarded
        ready_i = 1'b0;
        drive(8'h12, 8'h34, 1'b0, 1'b0); tick(model(8'h12, 8'h34, 1'b0, 1'b0), acc);
        drive(8'h21, 8'h43, 1'b1, 1'b0); tick(model(8'h21, 8'h43, 1'b1, 1'b0), acc);
        chk("inflight_valid", 32'(valid_o), 1);
        valid_i = 1'b0;
        rst_i   = 1'b1;
        tick('0, acc);
        chk("midrst_valid", 32'(valid_o), 0);
        chk("midrst_sum",   32'(sum_o),   0);
        n_disc += sbq.size();
        sbq.delete();
        rst_i   = 1'b0;
        ready_i = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready_o), 1);
        idle(S + 3);

        chk("sb_empty",  32'(sbq.size()), 0);
        chk("pop_count", 32'(n_pop), 32'(n_push - n_disc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
